flex_bus_ctrl: RTL and testbench
================================

Name: flex_bus_ctrl

Overview:
- Sequences one read or write access on the flex-bus between the SCU-bus slave front end and up to nr_slaves flexible peripherals.
- Registers the slave response and returns exactly one dtack pulse per access.
- Substitutes a timeout dtack when no slave answers, and flags/counts collisions where several slaves drive data_r_act.
- Sits between the SCU-bus slave macro and the slave-side response signals of the flex-bus hub.

Parameters:
data_bus_width, 16, width of read data bus
nr_slaves, 2, number of flex-bus slaves (>=1)
timeout_cycles, 32, clock cycles in WAIT before a timeout dtack (>=2)
timeout_data, 16'hDEAD, data_r value returned on a read timeout (truncated/zero-extended to data_bus_width)
cnt_width, 8, width of saturating error counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
ext_rd_active  in  1  master read strobe, held high for the access
ext_wr_active  in  1  master write strobe, held high for the access
sec_data_r  in  nr_slaves*data_bus_width  flattened slave read data; slave k occupies bits [(k+1)*W-1 : k*W]
sec_dtack  in  nr_slaves  per-slave acknowledge
sec_data_r_act  in  nr_slaves  per-slave read-active
err_clr  in  1  synchronous clear of err_count
data_r  out  data_bus_width  registered read data to master
dtack  out  1  one-cycle acknowledge to master
data_r_act  out  1  registered read-active, coincident with dtack
timeout_err  out  1  one-cycle pulse coincident with a timeout dtack
collision_err  out  1  one-cycle pulse coincident with dtack when >1 sec_data_r_act bits were set
err_count  out  cnt_width  saturating count of timeouts plus collisions
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, err_count 0. Asserting reset mid-access aborts it immediately; no dtack is issued after reset release.
- Strobe rise detection: strobe_q registers (rd|wr). An access starts only on a 0->1 rise, so a strobe held high never re-triggers. If rd and wr rise together, the access is a read.
- States: IDLE, WAIT, ACK, HOLD.
- IDLE: on a strobe rise, go to WAIT, clear timer, capture is_read.
- WAIT (timer increments every cycle):
  - Strobes both low: abort, go to IDLE, no dtack, no error.
  - Else if |sec_dtack: go to ACK, then take the first matching rule below.
    - Read with |sec_data_r_act: latch data_r from the lowest-index active slave, set data_r_act_next=1.
    - Read with no sec_data_r_act: data_r=0, data_r_act_next=0.
    - Write: data_r unchanged, data_r_act_next=0.
    - Collision = popcount(sec_data_r_act) > 1, latched.
  - Else if timer == timeout_cycles-1: go to ACK with timeout flag set. A read latches timeout_data with data_r_act_next=1; a write sets data_r_act_next=0.
  - A slave dtack in the same cycle as timer expiry counts as a normal ack; no timeout is flagged.
- ACK (exactly 1 cycle): dtack=1, data_r_act=data_r_act_next, timeout_err/collision_err = latched flags. Next state HOLD.
- HOLD: dtack=0 and data_r_act=0. data_r holds its value until the next latch. Stay until both strobes are low, then go to IDLE. Late or repeated sec_dtack in HOLD/IDLE is ignored.
- Latency: slave dtack sampled in cycle n gives master dtack in cycle n+1. A timeout dtack appears timeout_cycles+1 cycles after the strobe rise cycle.
- err_count:
  - +1 per timeout, +1 per collision.
  - +2 if both in the same access is impossible, because a timeout has no dtack; so at most +1 per access.
  - Saturates at all-ones.
  - err_clr has priority over an increment in the same cycle (result 0).

Decomposition:
- Package flex_bus_pkg holds:
  - state enum typedef (IDLE, WAIT, ACK, HOLD);
  - the default timeout_data constant;
  - the function popcount_gt1.
- One sub-module, flex_prio_sel: combinational lowest-index priority encoder over sec_data_r_act. Outputs are index, any, and multi. It is instantiated once and unit-tested separately.

Test Plan:
- Read, slave 1 asserts sec_data_r_act=2'b10, sec_dtack=2'b10 with data 16'h1234 three cycles after rd rise -> one cycle later dtack=1, data_r=16'h1234, data_r_act=1; no errors; busy until rd drops.
- Read, no slave responds, timeout_cycles=32 -> dtack at cycle 33 after rise, data_r=16'hDEAD, timeout_err=1, err_count=1.
- Read with sec_data_r_act=2'b11, data 16'hAAAA/16'h5555 -> data_r=16'h5555 (slave 0), collision_err=1, err_count increments.
- Write, slave 0 dtack -> dtack pulse, data_r_act=0, data_r unchanged. Strobe held 20 further cycles -> no second dtack.
- Strobe dropped in WAIT, then reset asserted mid-WAIT on a second access -> no dtack either time, outputs 0, state IDLE.
- err_count driven to 8'hFF -> stays 8'hFF on a further timeout. err_clr in the same cycle as a timeout -> 0.

Source files
------------

// File: rtl/flex_bus_pkg.sv
// Shared state type, default timeout word and bit-count helper for the flex-bus controller.
package flex_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } bus_state_e;

  localparam logic [15:0] DEFAULT_TIMEOUT_DATA = 16'hDEAD;
  localparam int          MAX_SLAVES           = 32;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_SLAVES-1:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/flex_prio_sel.sv
// Lowest-index priority encoder over the slave read-active vector.
module flex_prio_sel
  import flex_bus_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  act,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (act[k]) begin
        idx = IW'(k);
      end else begin
        idx = idx;
      end
    end
    any   = |act;
    multi = popcount_gt1(MAX_SLAVES'(act));
  end

endmodule

// File: rtl/flex_bus_ctrl.sv
// Sequences one flex-bus access per strobe rise and returns exactly one dtack,
// substituting a timeout response and flagging multi-slave read collisions.
module flex_bus_ctrl
  import flex_bus_pkg::*;
#(
  parameter int          data_bus_width = 16,
  parameter int          nr_slaves      = 2,
  parameter int          timeout_cycles = 32,
  parameter logic [15:0] timeout_data   = DEFAULT_TIMEOUT_DATA,
  parameter int          cnt_width      = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                ext_rd_active,
  input  logic                                ext_wr_active,
  input  logic [nr_slaves*data_bus_width-1:0] sec_data_r,
  input  logic [nr_slaves-1:0]                sec_dtack,
  input  logic [nr_slaves-1:0]                sec_data_r_act,
  input  logic                                err_clr,
  output logic [data_bus_width-1:0]           data_r,
  output logic                                dtack,
  output logic                                data_r_act,
  output logic                                timeout_err,
  output logic                                collision_err,
  output logic [cnt_width-1:0]                err_count,
  output logic                                busy
);

  localparam int IW = (nr_slaves > 1) ? $clog2(nr_slaves) : 1;
  localparam int TW = $clog2(timeout_cycles + 1);
  localparam logic [data_bus_width-1:0] TIMEOUT_WORD = data_bus_width'(timeout_data);
  localparam logic [TW-1:0]             TIMER_LAST   = TW'(timeout_cycles - 1);

  bus_state_e                state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      is_read_q, is_read_d;
  logic                      strobe_q, strobe_d;
  logic [data_bus_width-1:0] data_r_q, data_r_d;
  logic                      dtack_q, dtack_d;
  logic                      data_r_act_q, data_r_act_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      collision_err_q, collision_err_d;
  logic [cnt_width-1:0]      err_count_q, err_count_d;
  logic                      busy_q, busy_d;

  logic                      strobe_s;
  logic                      rise_s;
  logic                      err_inc_s;
  logic [IW-1:0]             sel_idx_s;
  logic                      sel_any_s;
  logic                      sel_multi_s;
  logic [data_bus_width-1:0] sel_data_s;

  flex_prio_sel #(.N(nr_slaves)) u_prio_sel (
    .act   (sec_data_r_act),
    .idx   (sel_idx_s),
    .any   (sel_any_s),
    .multi (sel_multi_s)
  );

  // Pick the read word of the winning slave out of the flattened bus.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < nr_slaves; k++) begin
      if (int'(sel_idx_s) == k) begin
        sel_data_s = sec_data_r[k*data_bus_width +: data_bus_width];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Access sequencing; response outputs are computed one cycle ahead so they leave flops.
  always_comb begin
    strobe_s        = ext_rd_active | ext_wr_active;
    rise_s          = strobe_s & ~strobe_q;
    strobe_d        = strobe_s;
    state_d         = state_q;
    timer_d         = timer_q;
    is_read_d       = is_read_q;
    data_r_d        = data_r_q;
    dtack_d         = 1'b0;
    data_r_act_d    = 1'b0;
    timeout_err_d   = 1'b0;
    collision_err_d = 1'b0;
    err_inc_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d   = WAIT;
          timer_d   = '0;
          is_read_d = ext_rd_active;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (!strobe_s) begin
          state_d = IDLE;
        end else if (|sec_dtack) begin
          state_d         = ACK;
          dtack_d         = 1'b1;
          collision_err_d = sel_multi_s;
          err_inc_s       = sel_multi_s;
          if (is_read_q && sel_any_s) begin
            data_r_d     = sel_data_s;
            data_r_act_d = 1'b1;
          end else if (is_read_q) begin
            data_r_d     = '0;
            data_r_act_d = 1'b0;
          end else begin
            data_r_d     = data_r_q;
            data_r_act_d = 1'b0;
          end
        end else if (timer_q == TIMER_LAST) begin
          // A slave dtack in this same cycle took the branch above, so no timeout then.
          state_d       = ACK;
          dtack_d       = 1'b1;
          timeout_err_d = 1'b1;
          err_inc_s     = 1'b1;
          if (is_read_q) begin
            data_r_d     = TIMEOUT_WORD;
            data_r_act_d = 1'b1;
          end else begin
            data_r_act_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!strobe_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_comb begin
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_inc_s && (err_count_q != {cnt_width{1'b1}})) begin
      err_count_d = err_count_q + cnt_width'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      is_read_q       <= 1'b0;
      strobe_q        <= 1'b0;
      data_r_q        <= '0;
      dtack_q         <= 1'b0;
      data_r_act_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
      collision_err_q <= 1'b0;
      err_count_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      is_read_q       <= is_read_d;
      strobe_q        <= strobe_d;
      data_r_q        <= data_r_d;
      dtack_q         <= dtack_d;
      data_r_act_q    <= data_r_act_d;
      timeout_err_q   <= timeout_err_d;
      collision_err_q <= collision_err_d;
      err_count_q     <= err_count_d;
      busy_q          <= busy_d;
    end
  end

  assign data_r        = data_r_q;
  assign dtack         = dtack_q;
  assign data_r_act    = data_r_act_q;
  assign timeout_err   = timeout_err_q;
  assign collision_err = collision_err_q;
  assign err_count     = err_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_flex_bus_ctrl.sv
// Randomised self-checking bench for flex_bus_ctrl against a per-access timing model.
module tb_flex_bus_ctrl;

  localparam int T = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ext_rd_active, ext_wr_active;
  logic [31:0] sec_data_r;
  logic [1:0]  sec_dtack, sec_data_r_act;
  logic        err_clr;
  logic [15:0] data_r;
  logic        dtack, data_r_act, timeout_err, collision_err, busy;
  logic [7:0]  err_count;

  logic [3:0]  p_act;
  logic [1:0]  p_idx;
  logic        p_any, p_multi;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_data = 16'h0000;
  int          m_cnt  = 0;

  always #5 clock = ~clock;

  flex_bus_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ext_rd_active  (ext_rd_active),
    .ext_wr_active  (ext_wr_active),
    .sec_data_r     (sec_data_r),
    .sec_dtack      (sec_dtack),
    .sec_data_r_act (sec_data_r_act),
    .err_clr        (err_clr),
    .data_r         (data_r),
    .dtack          (dtack),
    .data_r_act     (data_r_act),
    .timeout_err    (timeout_err),
    .collision_err  (collision_err),
    .err_count      (err_count),
    .busy           (busy)
  );

  flex_prio_sel #(.N(4)) u_sel (
    .act   (p_act),
    .idx   (p_idx),
    .any   (p_any),
    .multi (p_multi)
  );

  // One access: strobe rises now; slaves answer after `delay` edges (0 = never).
  task automatic do_access(input bit rd, input bit wr, input int delay,
                           input logic [1:0] act, input logic [1:0] dtk,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input bit clr, input int hold, input string tag);
    int exp_at;
    bit exp_to, exp_coll, exp_act, is_ack;
    exp_to   = !(delay >= 1 && delay <= T);
    exp_at   = exp_to ? T + 1 : delay + 1;
    exp_coll = !exp_to && ($countones(act) > 1);
    exp_act  = rd && (exp_to || act != 2'b00);
    ext_rd_active = rd;
    ext_wr_active = wr;
    sec_data_r    = {d1, d0};
    for (int k = 1; k <= exp_at + hold; k++) begin
      @(posedge clock);
      @(negedge clock);
      is_ack = (k == exp_at);
      if (is_ack) begin
        if (rd) begin
          if (exp_to)        m_data = 16'hDEAD;
          else if (act[0])   m_data = d0;
          else if (act[1])   m_data = d1;
          else               m_data = 16'h0000;
        end
        if (clr)                                    m_cnt = 0;
        else if ((exp_to || exp_coll) && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      total++;
      if (dtack !== is_ack) begin
        bad++; $display("FAIL %s dtack k=%0d got=%b exp=%b", tag, k, dtack, is_ack);
      end
      total++;
      if (data_r_act !== (is_ack && exp_act)) begin
        bad++; $display("FAIL %s data_r_act k=%0d got=%b exp=%b", tag, k, data_r_act, is_ack && exp_act);
      end
      total++;
      if (timeout_err !== (is_ack && exp_to)) begin
        bad++; $display("FAIL %s timeout_err k=%0d got=%b exp=%b", tag, k, timeout_err, is_ack && exp_to);
      end
      total++;
      if (collision_err !== (is_ack && exp_coll)) begin
        bad++; $display("FAIL %s collision_err k=%0d got=%b exp=%b", tag, k, collision_err, is_ack && exp_coll);
      end
      total++;
      if (data_r !== m_data) begin
        bad++; $display("FAIL %s data_r k=%0d got=%h exp=%h", tag, k, data_r, m_data);
      end
      total++;
      if (err_count !== 8'(m_cnt)) begin
        bad++; $display("FAIL %s err_count k=%0d got=%0d exp=%0d", tag, k, err_count, m_cnt);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL %s busy k=%0d got=%b exp=1", tag, k, busy);
      end
      if (k == delay) begin
        sec_dtack      = dtk;
        sec_data_r_act = act;
      end
      err_clr = clr && (k == exp_at - 1);
    end
    ext_rd_active  = 1'b0;
    ext_wr_active  = 1'b0;
    sec_dtack      = 2'b00;
    sec_data_r_act = 2'b00;
    err_clr        = 1'b0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if (busy !== (hold == 0) || dtack !== 1'b0) begin
      bad++; $display("FAIL %s release1 busy=%b dtack=%b exp busy=%b dtack=0", tag, busy, dtack, hold == 0);
    end
    @(posedge clock);
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || dtack !== 1'b0) begin
      bad++; $display("FAIL %s release2 busy=%b dtack=%b exp 0/0", tag, busy, dtack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ext_rd_active = 1'b0; ext_wr_active = 1'b0;
    sec_data_r = 32'h0; sec_dtack = 2'b00; sec_data_r_act = 2'b00; err_clr = 1'b0;
    p_act = 4'h0;
    repeat (3) @(negedge clock);
    total++;
    if ({dtack, data_r_act, timeout_err, collision_err, busy} !== 5'b0 || data_r !== 16'h0 || err_count !== 8'h0) begin
      bad++; $display("FAIL reset outputs dtack=%b act=%b to=%b col=%b busy=%b data=%h cnt=%0d exp all 0",
                      dtack, data_r_act, timeout_err, collision_err, busy, data_r, err_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0 || dtack !== 1'b0) begin
      bad++; $display("FAIL reset release busy=%b dtack=%b exp 0/0", busy, dtack);
    end
  endtask

  task automatic test_prio_sel();
    logic [1:0] e_idx;
    for (int v = 0; v < 16; v++) begin
      p_act = 4'(v);
      #1;
      e_idx = 2'd0;
      for (int b = 3; b >= 0; b--) if (p_act[b]) e_idx = 2'(b);
      total++;
      if (p_idx !== e_idx || p_any !== (v != 0) || p_multi !== ($countones(p_act) > 1)) begin
        bad++; $display("FAIL prio_sel act=%b got idx=%0d any=%b multi=%b exp idx=%0d any=%b multi=%b",
                        p_act, p_idx, p_any, p_multi, e_idx, v != 0, $countones(p_act) > 1);
      end
    end
  endtask

  task automatic test_directed();
    @(negedge clock);
    do_access(1'b1, 1'b0, 3, 2'b10, 2'b10, 16'h0BAD, 16'h1234, 1'b0, 2, "read_slave1");
    do_access(1'b1, 1'b0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1, "read_timeout");
    do_access(1'b1, 1'b0, 2, 2'b11, 2'b11, 16'h5555, 16'hAAAA, 1'b0, 1, "collision");
    do_access(1'b0, 1'b1, 2, 2'b00, 2'b01, 16'h7777, 16'h8888, 1'b0, 20, "write_hold");
  endtask

  task automatic test_boundary();
    do_access(1'b1, 1'b0, T, 2'b01, 2'b01, 16'hC0DE, 16'h0000, 1'b0, 1, "ack_at_expiry");
    do_access(1'b1, 1'b0, T + 1, 2'b01, 2'b01, 16'hBEEF, 16'h0000, 1'b0, 3, "late_ack");
    do_access(1'b1, 1'b1, 1, 2'b10, 2'b10, 16'h1111, 16'h2222, 1'b0, 0, "rd_wr_together");
    do_access(1'b1, 1'b0, 1, 2'b00, 2'b01, 16'h3333, 16'h4444, 1'b0, 0, "read_no_act");
    do_access(1'b0, 1'b1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 0, "write_timeout");
  endtask

  task automatic test_abort_and_reset();
    ext_rd_active = 1'b1;
    repeat (3) @(negedge clock);
    ext_rd_active = 1'b0;
    for (int k = 0; k < T + 5; k++) begin
      @(negedge clock);
      total++;
      if (dtack !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0 || err_count !== 8'(m_cnt)) begin
        bad++; $display("FAIL abort k=%0d dtack=%b to=%b busy=%b cnt=%0d exp 0/0/0/%0d",
                        k, dtack, timeout_err, busy, err_count, m_cnt);
      end
    end
    ext_wr_active = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    ext_wr_active = 1'b0;
    m_cnt = 0;
    m_data = 16'h0000;
    #1;
    total++;
    if ({dtack, data_r_act, timeout_err, collision_err, busy} !== 5'b0 || data_r !== 16'h0 || err_count !== 8'h0) begin
      bad++; $display("FAIL midreset outputs dtack=%b act=%b to=%b col=%b busy=%b data=%h cnt=%0d exp all 0",
                      dtack, data_r_act, timeout_err, collision_err, busy, data_r, err_count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < T + 5; k++) begin
      @(negedge clock);
      total++;
      if (dtack !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL post_reset k=%0d dtack=%b busy=%b exp 0/0", k, dtack, busy);
      end
    end
  endtask

  task automatic test_random();
    bit rd, wr, clr;
    int delay, sel, hold;
    logic [1:0] act, dtk;
    for (int n = 0; n < 40; n++) begin
      rd    = 1'($urandom_range(0, 1));
      wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      sel   = int'($urandom_range(0, 9));
      delay = (sel == 0) ? 0 : (sel == 1) ? T : int'($urandom_range(1, 6));
      act   = 2'($urandom_range(0, 3));
      dtk   = 2'($urandom_range(1, 3));
      clr   = ($urandom_range(0, 7) == 0);
      hold  = int'($urandom_range(0, 3));
      do_access(rd, wr, delay, act, dtk, 16'($urandom), 16'($urandom), clr, hold, "random");
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300 && m_cnt < 255; i++) begin
      do_access(1'b1, 1'b0, 1, 2'b11, 2'b11, 16'($urandom), 16'($urandom), 1'b0, 0, "sat_fill");
    end
    do_access(1'b1, 1'b0, 1, 2'b11, 2'b01, 16'h9999, 16'h6666, 1'b0, 0, "sat_collision");
    do_access(1'b1, 1'b0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 0, "sat_timeout");
    do_access(1'b1, 1'b0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 0, "clr_vs_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prio_sel();
    test_directed();
    test_boundary();
    test_abort_and_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
